// File: rtl/gshare_bp_pkg.sv
// Shared types, widths and helpers for the gshare branch predictor.
// Meta layout is a packed vector {ghr, idx, ctr}; the field offsets come from
// the helper functions below because every width is a parameter.
package gshare_bp_pkg;

   localparam int HASH_MODE_CONCAT = 0;
   localparam int HASH_MODE_XOR    = 1;

   localparam int DEF_GHR_W    = 4;
   localparam int DEF_PC_IDX_W = 4;
   localparam int DEF_CTR_W    = 2;

   // PHT index width for a given hash mode
   function automatic int idx_width(input int hash_xor, input int ghr_w, input int pc_idx_w);
      return (hash_xor == HASH_MODE_XOR) ? pc_idx_w : (ghr_w + pc_idx_w);
   endfunction

   function automatic int meta_ctr_lsb();
      return 0;
   endfunction

   function automatic int meta_idx_lsb(input int ctr_w);
      return ctr_w;
   endfunction

   function automatic int meta_ghr_lsb(input int idx_w, input int ctr_w);
      return idx_w + ctr_w;
   endfunction

   // Weakly not-taken: 0111..1 for a CTR_W-bit counter
   function automatic logic [31:0] ctr_reset_val(input int ctr_w);
      return (32'd1 << (ctr_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/gshare_bp_sat_counter.sv
// Next-state and direction logic for one saturating counter.
module sat_counter #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next,
   output logic             msb
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_MIN = '0;

   // Step toward the resolved direction, holding at either rail
   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_MAX) ctr_next = ctr + CTR_W'(1);
      end else begin
         if (ctr != CTR_MIN) ctr_next = ctr - CTR_W'(1);
      end
   end

   assign msb = ctr[CTR_W-1];

endmodule

// File: rtl/gshare_bp.sv
// Global-history (gshare) branch predictor for the RV32I fetch stage.
// Prediction is combinational from the fetch PC; training happens when the
// branch resolves, using the counter snapshot carried in the meta vector.
// Optional feature macro: GSHARE_SPEC_GHR_EN (speculative history with
// misprediction rollback). Without it pred_fire is ignored.
module gshare_bp
   import gshare_bp_pkg::*;
#(
   parameter int   GHR_W    = DEF_GHR_W,
   parameter int   PC_IDX_W = DEF_PC_IDX_W,
   parameter int   CTR_W    = DEF_CTR_W,
   parameter int   HASH_XOR = HASH_MODE_CONCAT,
   localparam int  IDX_W    = idx_width(HASH_XOR, GHR_W, PC_IDX_W),
   localparam int  META_W   = GHR_W + IDX_W + CTR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       imem_address,
   input  logic              pred_fire,
   output logic              pred_taken,
   output logic [META_W-1:0] pred_meta,
   input  logic              update,
   input  logic              br_taken,
   input  logic [META_W-1:0] upd_meta,
   output logic              mispredicted,
   output logic [31:0]       upd_count,
   output logic [31:0]       mp_count
);

   localparam int PHT_DEPTH = 2 ** IDX_W;
   localparam int CTR_LSB   = meta_ctr_lsb();
   localparam int IDX_LSB   = meta_idx_lsb(CTR_W);
   localparam int GHR_LSB   = meta_ghr_lsb(IDX_W, CTR_W);
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_reset_val(CTR_W));

   // Elaboration-time parameter sanity
   generate
      if (CTR_W < 2) begin : g_chk_ctr
         $error("gshare_bp: CTR_W must be at least 2");
      end
      if (GHR_W < 2) begin : g_chk_ghr
         $error("gshare_bp: GHR_W must be at least 2");
      end
      if (HASH_XOR == HASH_MODE_XOR && GHR_W > PC_IDX_W) begin : g_chk_xor
         $error("gshare_bp: XOR hashing needs GHR_W <= PC_IDX_W");
      end
   endgenerate

   logic [CTR_W-1:0]    pht [PHT_DEPTH];
   logic [GHR_W-1:0]    ghr;
   logic [GHR_W-1:0]    pred_history;
   logic [PC_IDX_W-1:0] pc_bits;
   logic [IDX_W-1:0]    pred_idx;
   logic [CTR_W-1:0]    pred_ctr;

   logic [IDX_W-1:0]    upd_idx;
   logic [CTR_W-1:0]    upd_ctr;
   logic [GHR_W-1:0]    upd_ghr;
   logic [CTR_W-1:0]    ctr_next;
   logic                upd_msb;

   assign pc_bits = imem_address[PC_IDX_W+1:2];

   generate
      if (HASH_XOR == HASH_MODE_XOR) begin : g_hash_xor
         assign pred_idx = pc_bits ^ IDX_W'(pred_history);
      end else begin : g_hash_cat
         assign pred_idx = {pred_history, pc_bits};
      end
   endgenerate

   assign pred_ctr   = pht[pred_idx];
   assign pred_taken = pred_ctr[CTR_W-1];
   assign pred_meta  = {pred_history, pred_idx, pred_ctr};

   assign upd_ctr = upd_meta[CTR_LSB +: CTR_W];
   assign upd_idx = upd_meta[IDX_LSB +: IDX_W];
   assign upd_ghr = upd_meta[GHR_LSB +: GHR_W];

   sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
      .ctr      (upd_ctr),
      .taken    (br_taken),
      .ctr_next (ctr_next),
      .msb      (upd_msb)
   );

   assign mispredicted = update & (upd_msb != br_taken);

   // PHT: reset to weakly not-taken, otherwise write the trained counter
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CTR_RST;
      end else if (update) begin
         pht[upd_idx] <= ctr_next;
      end
   end

   // Committed history shifts in every resolved direction
   always_ff @(posedge clk) begin
      if (rst) begin
         ghr <= '0;
      end else if (update) begin
         ghr <= {ghr[GHR_W-2:0], br_taken};
      end
   end

   // Resolution and misprediction counters, wrapping modulo 2^32
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_count <= '0;
         mp_count  <= '0;
      end else begin
         if (update)       upd_count <= upd_count + 32'd1;
         if (mispredicted) mp_count  <= mp_count + 32'd1;
      end
   end

`ifdef GSHARE_SPEC_GHR_EN
   logic [GHR_W-1:0] spec_ghr;

   // Speculative history: rollback on misprediction beats a same-cycle fire
   always_ff @(posedge clk) begin
      if (rst) begin
         spec_ghr <= '0;
      end else if (mispredicted) begin
         spec_ghr <= {upd_ghr[GHR_W-2:0], br_taken};
      end else if (pred_fire) begin
         spec_ghr <= {spec_ghr[GHR_W-2:0], pred_taken};
      end
   end

   assign pred_history = spec_ghr;

   logic unused_ok;
   assign unused_ok = ^{imem_address[31:PC_IDX_W+2], imem_address[1:0], upd_ghr[GHR_W-1]};
`else
   assign pred_history = ghr;

   logic unused_ok;
   assign unused_ok = ^{pred_fire, upd_ghr, imem_address[31:PC_IDX_W+2], imem_address[1:0]};
`endif

endmodule

// File: doc/gshare_bp.md
# gshare_bp

Parametrised global-history branch predictor for the RV32I fetch stage: a pattern history table (PHT) of saturating counters indexed by a hash of PC bits and a global history register (GHR). It predicts combinationally from the fetch address and trains when a branch resolves in MEM. It generalises the earlier 2-bit/4-bit-history predictor with configurable history, index and counter widths, XOR (gshare) or concatenated indexing, and performance counters. An optional speculative-history mode with misprediction rollback is compiled in by macro.

## Interface
- GHR_W, 4: global history bits.
- PC_IDX_W, 4: PC bits used, taken from imem_address[PC_IDX_W+1:2].
- CTR_W, 2: counter width, at least 2.
- HASH_XOR, 0: 0 = index {ghr, pc_bits}, IDX_W = GHR_W+PC_IDX_W. 1 = index pc_bits ^ zero-extended ghr, IDX_W = PC_IDX_W; GHR_W <= PC_IDX_W is required and is checked by an elaboration assertion.
- META_W (derived) = GHR_W+IDX_W+CTR_W; meta layout is {ghr, idx, ctr}.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_address  in  32  fetch PC.
- pred_fire  in  1  prediction consumed by a fetched branch. Used only with the macro.
- pred_taken  out  1  counter MSB of the indexed entry.
- pred_meta  out  META_W  history snapshot, index and counter, carried down the pipeline.
- update  in  1  a branch resolves this cycle.
- br_taken  in  1  resolved direction.
- upd_meta  in  META_W  pred_meta of the resolving branch.
- mispredicted  out  1  combinational; meaningful only when update is high.
- upd_count  out  32  number of resolved branches.
- mp_count  out  32  number of mispredictions.

## Operation
- Predict: idx = hash(pred_history, pc_bits); pred_taken = PHT[idx][CTR_W-1]; pred_meta = {pred_history, idx, PHT[idx]}.
- pred_history is the committed GHR, or the speculative GHR when the macro is set.
- Train on update, using the counter value carried in upd_meta, not a re-read of the PHT:
  - taken: ctr+1, saturating at 2^CTR_W-1.
  - not taken: ctr-1, saturating at 0.
  - result written to PHT[upd_meta.idx].
- Committed GHR <= {ghr[GHR_W-2:0], br_taken}.
- mispredicted = update & (upd_meta.ctr[CTR_W-1] != br_taken).
- upd_count increments on each update; mp_count increments on each misprediction. Both wrap modulo 2^32.
- Reset:
  - every PHT entry = 2^(CTR_W-1)-1 (weakly not-taken; 01 for CTR_W=2).
  - GHRs = 0, both counters = 0.
  - reset overrides a concurrent update or pred_fire.
- Same-index read and write in one cycle: the read returns the old value (no bypass).
- Back-to-back updates to one entry: each update trains from its own meta counter. The later write wins.

## Timing
- Prediction is zero latency, combinational from imem_address and registered state.
- PHT, GHR and counter updates become visible the cycle after update.
- mispredicted is valid in the same cycle as update, so MEM can flush.
- No handshake. update and pred_fire are single-cycle qualifiers and may be high every cycle.

## Configuration
- GSHARE_SPEC_GHR_EN defined:
  - A speculative GHR drives prediction.
  - On pred_fire it shifts in pred_taken.
  - On a misprediction it is restored to {upd_meta.ghr[GHR_W-2:0], br_taken}.
  - If recovery and pred_fire fall in the same cycle, recovery wins and pred_fire is dropped.
  - A correct update leaves the speculative GHR unchanged.
- GSHARE_SPEC_GHR_EN undefined:
  - The speculative register is absent, pred_fire is ignored, and prediction uses the committed GHR.

## Structure
- The types package gains:
  - ctr_reset_val(CTR_W) function.
  - the hash-mode localparams.
  - default width constants.
- The meta layout is a packed vector with the field offsets defined in the package, because the widths are parametric.
- Sub-module sat_counter (CTR_W): the next-state and MSB logic for one counter, instanced once on the update path.

## Test plan
- Reset with defaults: pred_taken=0, pred_meta ctr=01, upd_count=mp_count=0.
- Four taken updates to PC 0x4, ghr held fixed by replaying the same meta: ctr goes 01→10→11→11. mispredicted pulses only on the first update. mp_count=1.
- HASH_XOR=1, GHR_W=PC_IDX_W=4, ghr=1010, PC 0x8 (pc_bits 0010): idx=1000. Concat mode, same inputs: idx=1010_0010.
- Macro set: three pred_fire with pred_taken=0, then an update with meta ghr=0000, pred not-taken and br_taken=1. mispredicted=1 and the speculative GHR becomes 0001 next cycle. Repeat with pred_fire in the same cycle: still 0001.
- Macro unset: pred_fire toggling leaves pred_meta.ghr unchanged. Only update shifts the GHR.
- rst asserted in the same cycle as update: no PHT write, and all state is at reset values next cycle.
